// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Brief    : Register-file write-port controller: post-reset scrub of x1..x31,
//            then round-robin arbitration between ALU and load writebacks.
// Revision : 1.0
// ============================================================================
module regfile_wb_arbiter #(
    parameter int INIT_EN = 1
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic        A_Valid,
    input  logic [4:0]  A_Wr,
    input  logic [31:0] A_D,
    output logic        A_Ready,
    input  logic        B_Valid,
    input  logic [4:0]  B_Wr,
    input  logic [31:0] B_D,
    output logic        B_Ready,
    output logic        We,
    output logic [4:0]  Wr,
    output logic [31:0] D,
    output logic        Init_Done
);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam state_t     c_RST_STATE = (INIT_EN != 0) ? ST_INIT : ST_RUN;
    localparam logic [4:0] c_LAST_ADDR = 5'd31;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [4:0]  r_cnt;
    logic        r_pri;
    logic        r_we;
    logic [4:0]  r_wr;
    logic [31:0] r_d;
    logic        w_grant_a;
    logic        w_grant_b;

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            r_state <= c_RST_STATE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // r_pri names the requester favoured when both are valid (0 = A, 1 = B).
    always_comb begin
        w_state_nxt = r_state;
        w_grant_a   = 1'b0;
        w_grant_b   = 1'b0;
        case (r_state)
            ST_INIT: begin
                if (r_cnt == c_LAST_ADDR) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_grant_a = A_Valid && (!B_Valid || !r_pri);
                w_grant_b = B_Valid && (!A_Valid ||  r_pri);
            end
            default: begin
                w_state_nxt = c_RST_STATE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            r_cnt <= 5'd1;
            r_pri <= 1'b0;
            r_we  <= 1'b0;
            r_wr  <= 5'd0;
            r_d   <= 32'd0;
        end else if (r_state == ST_INIT) begin
            r_we <= 1'b1;
            r_wr <= r_cnt;
            r_d  <= 32'd0;
            // Counter parks at 31 once the sweep reaches the last register.
            if (r_cnt != c_LAST_ADDR) begin
                r_cnt <= r_cnt + 5'd1;
            end
        end else if (w_grant_a) begin
            r_we  <= (A_Wr != 5'd0);
            r_wr  <= A_Wr;
            r_d   <= A_D;
            r_pri <= 1'b1;
        end else if (w_grant_b) begin
            r_we  <= (B_Wr != 5'd0);
            r_wr  <= B_Wr;
            r_d   <= B_D;
            r_pri <= 1'b0;
        end else begin
            r_we <= 1'b0;
        end
    end

    assign A_Ready   = w_grant_a;
    assign B_Ready   = w_grant_b;
    assign We        = r_we;
    assign Wr        = r_wr;
    assign D         = r_d;
    assign Init_Done = (r_state == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_arbiter
// Brief    : Bench for regfile_wb_arbiter: reference model plus directed and
//            random writeback traffic, including resets mid-sweep and mid-run.
// Revision : 1.0
// ============================================================================
module tb_regfile_wb_arbiter;

    logic        Clk = 1'b0;
    logic        Clr = 1'b1;
    logic        A_Valid = 1'b0;
    logic [4:0]  A_Wr = 5'd0;
    logic [31:0] A_D = 32'd0;
    logic        B_Valid = 1'b0;
    logic [4:0]  B_Wr = 5'd0;
    logic [31:0] B_D = 32'd0;
    logic        A_Ready;
    logic        B_Ready;
    logic        We;
    logic [4:0]  Wr;
    logic [31:0] D;
    logic        Init_Done;

    regfile_wb_arbiter #(.INIT_EN(1)) dut (
        .Clk       (Clk),
        .Clr       (Clr),
        .A_Valid   (A_Valid),
        .A_Wr      (A_Wr),
        .A_D       (A_D),
        .A_Ready   (A_Ready),
        .B_Valid   (B_Valid),
        .B_Wr      (B_Wr),
        .B_D       (B_D),
        .B_Ready   (B_Ready),
        .We        (We),
        .Wr        (Wr),
        .D         (D),
        .Init_Done (Init_Done)
    );

    always #10 Clk = ~Clk;

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit cmp_en    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    endtask

    // Reference model: edges since reset, last winner, expected port outputs.
    int          m_edges;
    bit          m_last_b;
    bit          m_we;
    logic [4:0]  m_wr;
    logic [31:0] m_d;
    logic [31:0] m_rf [32];
    logic [31:0] dut_rf [32];
    int          r0_writes = 0;

    function automatic bit m_in_init();
        return m_edges < 31;
    endfunction

    // On conflict the requester that did not win last time goes first.
    function automatic bit want_a();
        if (m_in_init() || !A_Valid) return 1'b0;
        if (!B_Valid) return 1'b1;
        return m_last_b;
    endfunction

    function automatic bit want_b();
        if (m_in_init() || !B_Valid) return 1'b0;
        if (!A_Valid) return 1'b1;
        return !m_last_b;
    endfunction

    always @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            m_edges  <= 0;
            m_last_b <= 1'b1;
            m_we     <= 1'b0;
            m_wr     <= 5'd0;
            m_d      <= 32'd0;
        end else begin
            if (m_we) m_rf[m_wr] <= m_d;
            if (m_in_init()) begin
                m_we    <= 1'b1;
                m_wr    <= 5'(m_edges + 1);
                m_d     <= 32'd0;
                m_edges <= m_edges + 1;
            end else if (want_a()) begin
                m_we     <= (A_Wr != 5'd0);
                m_wr     <= A_Wr;
                m_d      <= A_D;
                m_last_b <= 1'b0;
            end else if (want_b()) begin
                m_we     <= (B_Wr != 5'd0);
                m_wr     <= B_Wr;
                m_d      <= B_D;
                m_last_b <= 1'b1;
            end else begin
                m_we <= 1'b0;
            end
        end
    end

    // Register file as driven by the DUT's write port; x0 is hardwired.
    always @(posedge Clk) begin
        if (We && Wr != 5'd0) dut_rf[Wr] <= D;
        if (We && Wr == 5'd0) r0_writes <= r0_writes + 1;
    end

    always @(negedge Clk) begin
        #2;
        if (cmp_en) begin
            chk("a_ready",   {31'd0, A_Ready},   {31'd0, want_a()});
            chk("b_ready",   {31'd0, B_Ready},   {31'd0, want_b()});
            chk("we",        {31'd0, We},        {31'd0, m_we});
            chk("wr",        {27'd0, Wr},        {27'd0, m_wr});
            chk("d",         D,                  m_d);
            chk("init_done", {31'd0, Init_Done}, {31'd0, !m_in_init()});
        end
    end

    task automatic tick(input bit av, input logic [4:0] aw, input logic [31:0] ad,
                        input bit bv, input logic [4:0] bw, input logic [31:0] bd,
                        output bit ra, output bit rb);
        @(negedge Clk);
        A_Valid = av; A_Wr = aw; A_D = ad;
        B_Valid = bv; B_Wr = bw; B_D = bd;
        #3;
        ra = A_Ready;
        rb = B_Ready;
    endtask

    task automatic idle();
        bit ra, rb;
        tick(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ra, rb);
    endtask

    // Called just after a tick; asserts Clr before the next rising edge.
    task automatic clr_pulse(input string tag);
        #1 Clr = 1'b1;
        #1;
        chk({tag, "_we"},   {31'd0, We}, 32'd0);
        chk({tag, "_wr"},   {27'd0, Wr}, 32'd0);
        chk({tag, "_d"},    D,           32'd0);
        chk({tag, "_rdy"},  {30'd0, A_Ready, B_Ready}, 32'd0);
        chk({tag, "_done"}, {31'd0, Init_Done}, 32'd0);
        @(negedge Clk);
        #4 Clr = 1'b0;
    endtask

    initial begin
        bit ra, rb;
        bit a_pend, b_pend;
        logic [4:0]  a_wr, b_wr;
        logic [31:0] a_dat, b_dat;
        string seq;

        repeat (2) @(negedge Clk);
        #4 Clr = 1'b0;
        cmp_en = 1'b1;
        #1;
        chk("rst_we",   {31'd0, We}, 32'd0);
        chk("rst_wr",   {27'd0, Wr}, 32'd0);
        chk("rst_done", {31'd0, Init_Done}, 32'd0);

        for (int k = 1; k <= 31; k++) begin
            idle();
            if (k == 1)  chk("sweep_first_wr", {27'd0, Wr}, 32'd1);
            if (k == 30) chk("sweep_done30",   {31'd0, Init_Done}, 32'd0);
            if (k == 31) begin
                chk("sweep_done31", {31'd0, Init_Done}, 32'd1);
                chk("sweep_last_wr", {27'd0, Wr}, 32'd31);
            end
        end
        idle();
        chk("sweep_end_we", {31'd0, We}, 32'd0);

        // Single A write.
        tick(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, ra, rb);
        chk("a_only_ready", {31'd0, ra}, 32'd1);
        idle();
        chk("a_only_we", {31'd0, We}, 32'd1);
        chk("a_only_wr", {27'd0, Wr}, 32'd5);
        chk("a_only_d",  D, 32'hDEADBEEF);
        idle();
        chk("rf5", dut_rf[5], 32'hDEADBEEF);

        // B-only write hands priority back to A.
        tick(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h44, ra, rb);
        chk("b_only_ready", {31'd0, rb}, 32'd1);

        // Sustained contention alternates A, B, A, B.
        a_dat = 32'h30; b_dat = 32'h70; seq = "";
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 5'd3, a_dat, 1'b1, 5'd7, b_dat, ra, rb);
            seq = {seq, ra ? "A" : "", rb ? "B" : ""};
            if (ra) a_dat++;
            if (rb) b_dat++;
        end
        chk("rr_seq_len", seq.len(), 32'd4);
        if (seq.len() == 4) chk("rr_seq", {seq[0], seq[1], seq[2], seq[3]}, "ABAB");

        // Same address: A wins first (priority back at A), B's data persists.
        tick(1'b1, 5'd9, 32'h1, 1'b1, 5'd9, 32'h2, ra, rb);
        chk("same_addr_a_first", {30'd0, ra, rb}, 32'd2);
        tick(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h2, ra, rb);
        chk("same_addr_b_next", {31'd0, rb}, 32'd1);
        idle();
        idle();
        chk("rf9", dut_rf[9], 32'h2);

        // Write to x0 handshakes but does not enable.
        tick(1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 32'd0, ra, rb);
        chk("x0_ready", {31'd0, ra}, 32'd1);
        idle();
        chk("x0_we", {31'd0, We}, 32'd0);
        chk("x0_wr", {27'd0, Wr}, 32'd0);
        chk("x0_d",  D, 32'h12345678);

        // Clr during an accepted handshake: the write is lost and INIT reruns.
        tick(1'b1, 5'd12, 32'hCAFEF00D, 1'b0, 5'd0, 32'd0, ra, rb);
        chk("hs_ready", {31'd0, ra}, 32'd1);
        A_Valid = 1'b0;
        clr_pulse("clr_run");
        idle();
        chk("rerun_wr", {27'd0, Wr}, 32'd1);
        chk("rerun_we", {31'd0, We}, 32'd1);

        // Clr at INIT cycle 10: the sweep restarts from x1.
        repeat (9) idle();
        chk("init10_wr", {27'd0, Wr}, 32'd10);
        clr_pulse("clr_init");
        idle();
        chk("restart_wr", {27'd0, Wr}, 32'd1);
        repeat (30) idle();
        chk("restart_done", {31'd0, Init_Done}, 32'd1);

        // Random traffic with requesters that hold until accepted.
        a_pend = 1'b0; b_pend = 1'b0;
        a_wr = 5'd0; b_wr = 5'd0; a_dat = 32'd0; b_dat = 32'd0;
        for (int n = 0; n < 800; n++) begin
            if (!a_pend && ($urandom % 3 != 0)) begin
                a_pend = 1'b1;
                a_wr   = ($urandom % 4 == 0) ? 5'($urandom % 4) : 5'($urandom % 32);
                a_dat  = $urandom;
            end
            if (!b_pend && ($urandom % 3 != 0)) begin
                b_pend = 1'b1;
                b_wr   = ($urandom % 4 == 0) ? 5'($urandom % 4) : 5'($urandom % 32);
                b_dat  = $urandom;
            end
            tick(a_pend, a_wr, a_dat, b_pend, b_wr, b_dat, ra, rb);
            if (ra) a_pend = 1'b0;
            if (rb) b_pend = 1'b0;
            if (n == 400) clr_pulse("clr_rand");
        end
        repeat (3) idle();

        for (int i = 1; i < 32; i++) chk($sformatf("rf_x%0d", i), dut_rf[i], m_rf[i]);
        chk("x0_never_written", r0_writes, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
